// File: rtl/uart_apb_regs.sv
// APB register front end for the UART core: decodes APB accesses into CSN/WEN/OEN strobes,
// holds baud/frame configuration, and aggregates status with sticky errors and a maskable IRQ.
module uart_apb_regs #(
  parameter logic [12:0] BAUD_VAL_RST = 13'd1,
  parameter logic [2:0]  CFG_RST      = 3'b001
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [4:0]  PADDR,
  input  logic [7:0]  PWDATA,
  output logic [7:0]  PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        CSN,
  output logic        WEN,
  output logic        OEN,
  output logic [7:0]  DATA_IN,
  input  logic [7:0]  DATA_OUT,
  input  logic        TXRDY,
  input  logic        RXRDY,
  input  logic        PARITY_ERR,
  input  logic        OVERFLOW,
  input  logic        FRAMING_ERR,
  output logic [12:0] BAUD_VAL,
  output logic [2:0]  BAUD_VAL_FRACTION,
  output logic        BIT8,
  output logic        PARITY_EN,
  output logic        ODD_N_EVEN,
  output logic        IRQ
);

  localparam logic [2:0] AddrTx     = 3'd0;
  localparam logic [2:0] AddrRx     = 3'd1;
  localparam logic [2:0] AddrBaudLo = 3'd2;
  localparam logic [2:0] AddrBaudHi = 3'd3;
  localparam logic [2:0] AddrCfg    = 3'd4;
  localparam logic [2:0] AddrStatus = 3'd5;
  localparam logic [2:0] AddrIrqEn  = 3'd6;
  localparam logic [2:0] AddrRsvd   = 3'd7;

  typedef enum logic [1:0] {StIdle, StRdStrobe, StRdDone} rd_state_e;

  rd_state_e   state_q;
  logic        csn_q, wen_q, oen_q;
  logic [7:0]  data_in_q, hold_q;
  logic [12:0] baud_q;
  logic [2:0]  frac_q, fmt_q, irq_en_q;
  logic [3:0]  sticky_q, sticky_d;  // {tx_drop, framing, overflow, parity}
  logic        irq_q;

  logic [2:0] addr;
  logic       access, idle, rx_rd, wr_en, rd_en, tx_wr, status_clr, tx_drop;
  logic       unused_paddr;

  assign addr         = PADDR[4:2];
  assign unused_paddr = ^PADDR[1:0];
  assign access       = PSEL & PENABLE;
  assign idle         = (state_q == StIdle);
  assign rx_rd        = access & ~PWRITE & (addr == AddrRx);
  assign wr_en        = access & PWRITE & idle;
  assign rd_en        = access & ~PWRITE & idle;
  assign tx_wr        = wr_en & (addr == AddrTx);
  assign tx_drop      = tx_wr & ~TXRDY;
  assign status_clr   = rd_en & (addr == AddrStatus);

  // Set wins over a coincident clear so no error event is ever lost.
  assign sticky_d = (sticky_q & {4{~status_clr}}) |
                    {tx_drop, FRAMING_ERR, OVERFLOW, PARITY_ERR};

  assign PREADY  = idle ? ~rx_rd : (state_q == StRdDone);
  assign PSLVERR = access & ((addr == AddrRsvd) |
                             (PWRITE & ((addr == AddrRx) | (addr == AddrStatus))));

  always_comb begin
    PRDATA = 8'h00;
    if (state_q == StRdDone) begin
      PRDATA = hold_q;
    end else if (rd_en) begin
      case (addr)
        AddrBaudLo: PRDATA = baud_q[7:0];
        AddrBaudHi: PRDATA = {3'b000, baud_q[12:8]};
        AddrCfg:    PRDATA = {2'b00, frac_q, fmt_q};
        AddrStatus: PRDATA = {2'b00, sticky_q, RXRDY, TXRDY};
        AddrIrqEn:  PRDATA = {5'b00000, irq_en_q};
        default:    PRDATA = 8'h00;
      endcase
    end
  end

  // RX read sequencer and UART-side strobes; strobes default high every cycle.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      csn_q     <= 1'b1;
      wen_q     <= 1'b1;
      oen_q     <= 1'b1;
      data_in_q <= 8'h00;
      hold_q    <= 8'h00;
    end else begin
      csn_q <= 1'b1;
      wen_q <= 1'b1;
      oen_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (rx_rd) begin
            state_q <= StRdStrobe;
            csn_q   <= 1'b0;
            oen_q   <= 1'b0;
          end else if (tx_wr && TXRDY) begin
            csn_q     <= 1'b0;
            wen_q     <= 1'b0;
            data_in_q <= PWDATA;
          end
        end
        StRdStrobe: begin
          hold_q  <= DATA_OUT;
          state_q <= StRdDone;
        end
        StRdDone: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      baud_q   <= BAUD_VAL_RST;
      frac_q   <= 3'b000;
      fmt_q    <= CFG_RST;
      irq_en_q <= 3'b000;
      sticky_q <= 4'b0000;
      irq_q    <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          AddrBaudLo: baud_q[7:0]  <= PWDATA;
          AddrBaudHi: baud_q[12:8] <= PWDATA[4:0];
          AddrCfg: begin
            fmt_q  <= PWDATA[2:0];
            frac_q <= PWDATA[5:3];
          end
          AddrIrqEn:  irq_en_q <= PWDATA[2:0];
          default: ;
        endcase
      end
      sticky_q <= sticky_d;
      irq_q    <= |(irq_en_q & {|sticky_q, RXRDY, TXRDY});
    end
  end

  assign CSN               = csn_q;
  assign WEN               = wen_q;
  assign OEN               = oen_q;
  assign DATA_IN           = data_in_q;
  assign BAUD_VAL          = baud_q;
  assign BAUD_VAL_FRACTION = frac_q;
  assign BIT8              = fmt_q[0];
  assign PARITY_EN         = fmt_q[1];
  assign ODD_N_EVEN        = fmt_q[2];
  assign IRQ               = irq_q;

endmodule

// File: tb/tb_uart_apb_regs.sv
// Bench for uart_apb_regs: transaction-level register model, per-cycle output compare,
// directed literal checks and a randomized APB/status stimulus phase.
module tb_uart_apb_regs;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic        PSEL, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [7:0]  PWDATA, PRDATA, DATA_IN, DATA_OUT;
  logic        PREADY, PSLVERR, CSN, WEN, OEN;
  logic        TXRDY, RXRDY, PARITY_ERR, OVERFLOW, FRAMING_ERR;
  logic [12:0] BAUD_VAL;
  logic [2:0]  BAUD_VAL_FRACTION;
  logic        BIT8, PARITY_EN, ODD_N_EVEN, IRQ;

  uart_apb_regs dut (
    .CLK(CLK), .RESET_N(RESET_N), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .CSN(CSN), .WEN(WEN), .OEN(OEN), .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT),
    .TXRDY(TXRDY), .RXRDY(RXRDY), .PARITY_ERR(PARITY_ERR), .OVERFLOW(OVERFLOW),
    .FRAMING_ERR(FRAMING_ERR), .BAUD_VAL(BAUD_VAL), .BAUD_VAL_FRACTION(BAUD_VAL_FRACTION),
    .BIT8(BIT8), .PARITY_EN(PARITY_EN), .ODD_N_EVEN(ODD_N_EVEN), .IRQ(IRQ)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Model of the register file and expected outputs.
  logic [12:0] m_baud;
  logic [2:0]  m_frac, m_fmt, m_irq_en;
  logic [3:0]  m_sticky;
  logic [7:0]  m_data_in;
  logic        m_irq, m_csn, m_wen, m_oen;
  // Events that take effect at the next clock edge.
  bit          f_clr, f_drop, f_txstb, f_rxstb, f_wr;
  logic [2:0]  f_wa;
  logic [7:0]  f_wd;
  bit          rand_on = 1'b0;
  bit          chk_on  = 1'b0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_baud = 13'd1; m_frac = 3'd0; m_fmt = 3'b001; m_irq_en = 3'd0;
    m_sticky = 4'd0; m_data_in = 8'h00; m_irq = 1'b0;
    m_csn = 1'b1; m_wen = 1'b1; m_oen = 1'b1;
    f_clr = 0; f_drop = 0; f_txstb = 0; f_rxstb = 0; f_wr = 0;
  endtask

  function automatic logic [7:0] model_rd(input logic [2:0] a);
    case (a)
      3'd2:    return m_baud[7:0];
      3'd3:    return {3'b000, m_baud[12:8]};
      3'd4:    return {2'b00, m_frac, m_fmt};
      3'd5:    return {2'b00, m_sticky, RXRDY, TXRDY};
      3'd6:    return {5'b00000, m_irq_en};
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit is_err(input logic [2:0] a, input bit w);
    return (a == 3'd7) || (w && (a == 3'd1 || a == 3'd5));
  endfunction

  // Advance one clock: model consumes the levels held before the edge, then inputs may change.
  task automatic cycle();
    logic [3:0] st_n;
    logic       irq_n;
    st_n  = (f_clr ? 4'b0000 : m_sticky) | {f_drop, FRAMING_ERR, OVERFLOW, PARITY_ERR};
    irq_n = |(m_irq_en & {|m_sticky, RXRDY, TXRDY});
    @(posedge CLK);
    m_sticky = st_n;
    m_irq    = irq_n;
    m_csn    = !(f_txstb || f_rxstb);
    m_wen    = !f_txstb;
    m_oen    = !f_rxstb;
    if (f_txstb) m_data_in = f_wd;
    if (f_wr) begin
      case (f_wa)
        3'd2: m_baud[7:0] = f_wd;
        3'd3: m_baud[12:8] = f_wd[4:0];
        3'd4: begin m_fmt = f_wd[2:0]; m_frac = f_wd[5:3]; end
        3'd6: m_irq_en = f_wd[2:0];
        default: ;
      endcase
    end
    f_clr = 0; f_drop = 0; f_txstb = 0; f_rxstb = 0; f_wr = 0;
    #1;
    if (rand_on) begin
      TXRDY       = ($urandom % 4) != 0;
      RXRDY       = $urandom % 2;
      PARITY_ERR  = ($urandom % 16) == 0;
      OVERFLOW    = ($urandom % 16) == 0;
      FRAMING_ERR = ($urandom % 16) == 0;
      DATA_OUT    = 8'($urandom);
    end
  endtask

  task automatic apb_write(input logic [2:0] a, input logic [7:0] d);
    PSEL = 1; PENABLE = 0; PWRITE = 1; PADDR = {a, 2'($urandom)}; PWDATA = d;
    cycle();
    PENABLE = 1;
    @(negedge CLK);
    chk("wr_pready", PREADY, 1);
    chk("wr_pslverr", PSLVERR, is_err(a, 1));
    if (a == 3'd0) begin
      if (TXRDY) begin f_txstb = 1; f_wd = d; end
      else f_drop = 1;
    end else if (a == 3'd2 || a == 3'd3 || a == 3'd4 || a == 3'd6) begin
      f_wr = 1; f_wa = a; f_wd = d;
    end
    cycle();
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic apb_read(input logic [2:0] a, output logic [7:0] got);
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = {a, 2'($urandom)};
    cycle();
    PENABLE = 1;
    @(negedge CLK);
    got = PRDATA;
    chk("rd_pready", PREADY, 1);
    chk("rd_pslverr", PSLVERR, is_err(a, 0));
    chk("rd_data", PRDATA, model_rd(a));
    if (a == 3'd5) f_clr = 1;
    cycle();
    PSEL = 0; PENABLE = 0;
  endtask

  task automatic rx_read(output logic [7:0] got);
    logic [7:0] exp;
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = {3'd1, 2'($urandom)};
    cycle();
    PENABLE = 1;
    @(negedge CLK);
    chk("rx_wait1", PREADY, 0);
    f_rxstb = 1;
    cycle();
    @(negedge CLK);
    chk("rx_wait2", PREADY, 0);
    exp = DATA_OUT;
    cycle();
    @(negedge CLK);
    chk("rx_pready", PREADY, 1);
    chk("rx_pslverr", PSLVERR, 0);
    chk("rx_data", PRDATA, exp);
    got = PRDATA;
    cycle();
    PSEL = 0; PENABLE = 0;
  endtask

  always @(negedge CLK) begin
    if (chk_on) begin
      chk("baud_val", BAUD_VAL, m_baud);
      chk("fraction", BAUD_VAL_FRACTION, m_frac);
      chk("format", {ODD_N_EVEN, PARITY_EN, BIT8}, m_fmt);
      chk("data_in", DATA_IN, m_data_in);
      chk("irq", IRQ, m_irq);
      chk("strobes", {CSN, WEN, OEN}, {m_csn, m_wen, m_oen});
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] got;
    RESET_N = 0; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    DATA_OUT = 0; TXRDY = 0; RXRDY = 0; PARITY_ERR = 0; OVERFLOW = 0; FRAMING_ERR = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_prdata", PRDATA, 8'h00);
    chk("rst_pready", PREADY, 1);
    chk("rst_pslverr", PSLVERR, 0);
    chk("rst_strobes", {CSN, WEN, OEN}, 3'b111);
    chk("rst_data_in", DATA_IN, 8'h00);
    chk("rst_baud", BAUD_VAL, 13'd1);
    chk("rst_frac", BAUD_VAL_FRACTION, 3'd0);
    chk("rst_fmt", {ODD_N_EVEN, PARITY_EN, BIT8}, 3'b001);
    chk("rst_irq", IRQ, 0);
    @(posedge CLK); #1;
    RESET_N = 1; chk_on = 1;

    // Configuration write and readback
    apb_write(3'd2, 8'h5A);
    apb_write(3'd3, 8'h13);
    apb_write(3'd4, 8'h2D);
    @(negedge CLK);
    chk("cfg_baud_lit", BAUD_VAL, 13'h135A);
    chk("cfg_frac_lit", BAUD_VAL_FRACTION, 3'd5);
    chk("cfg_fmt_lit", {ODD_N_EVEN, PARITY_EN, BIT8}, 3'b101);
    apb_read(3'd2, got); chk("rb_lo_lit", got, 8'h5A);
    apb_read(3'd3, got); chk("rb_hi_lit", got, 8'h13);
    apb_read(3'd4, got); chk("rb_cfg_lit", got, 8'h2D);

    // TX strobe, then dropped write
    TXRDY = 1;
    apb_write(3'd0, 8'hA5);
    @(negedge CLK);
    chk("tx_strobe_lit", {CSN, WEN, OEN}, 3'b001);
    chk("tx_data_lit", DATA_IN, 8'hA5);
    cycle();
    @(negedge CLK);
    chk("tx_strobe_end_lit", {CSN, WEN, OEN}, 3'b111);
    TXRDY = 0;
    apb_write(3'd0, 8'h3F);
    @(negedge CLK);
    chk("tx_drop_nostb_lit", {CSN, WEN, DATA_IN}, {2'b11, 8'hA5});
    apb_read(3'd5, got); chk("tx_drop_status_lit", got, 8'h20);

    // RX read
    DATA_OUT = 8'h3C;
    rx_read(got); chk("rx_data_lit", got, 8'h3C);

    // Sticky parity, IRQ, clear, and set-wins-over-clear
    apb_write(3'd6, 8'h04);
    PARITY_ERR = 1; cycle(); PARITY_ERR = 0; cycle();
    @(negedge CLK);
    chk("irq_lit", IRQ, 1);
    apb_read(3'd5, got); chk("par_status_lit", got, 8'h04);
    apb_read(3'd5, got); chk("par_cleared_lit", got, 8'h00);
    PARITY_ERR = 1;
    apb_read(3'd5, got);
    PARITY_ERR = 0;
    apb_read(3'd5, got); chk("set_wins_lit", got, 8'h04);
    apb_read(3'd5, got); chk("set_wins_clr_lit", got, 8'h00);

    // Error responses
    apb_write(3'd7, 8'hFF);
    apb_read(3'd7, got); chk("rsvd_rd_lit", got, 8'h00);
    apb_write(3'd5, 8'hFF);
    apb_write(3'd1, 8'hFF);
    apb_read(3'd5, got); chk("err_wr_status_lit", got, 8'h00);

    // PSEL dropped during wait states
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = {3'd1, 2'b00};
    cycle();
    PENABLE = 1;
    @(negedge CLK);
    f_rxstb = 1;
    cycle();
    PSEL = 0; PENABLE = 0;
    cycle(); cycle();
    apb_read(3'd2, got);

    // Reset in the middle of an RX read
    PSEL = 1; PENABLE = 0; PWRITE = 0; PADDR = {3'd1, 2'b00};
    cycle();
    PENABLE = 1;
    @(negedge CLK);
    f_rxstb = 1;
    cycle();
    @(negedge CLK);
    chk("mid_rst_csn_low_lit", CSN, 0);
    chk_on = 0;
    #1 RESET_N = 0;
    #1;
    chk("mid_rst_strobes_lit", {CSN, WEN, OEN}, 3'b111);
    chk("mid_rst_baud_lit", BAUD_VAL, 13'd1);
    PSEL = 0; PENABLE = 0;
    model_reset();
    @(posedge CLK); #1;
    RESET_N = 1; chk_on = 1;
    DATA_OUT = 8'h77;
    rx_read(got); chk("post_rst_rx_lit", got, 8'h77);

    // Randomized traffic
    rand_on = 1;
    repeat (400) begin
      int unsigned op;
      logic [2:0]  a;
      op = $urandom % 8;
      a  = 3'($urandom);
      if (op < 3) apb_write(a, 8'($urandom));
      else if (op < 6) begin
        if (a == 3'd1) rx_read(got);
        else apb_read(a, got);
      end else if (op == 6) rx_read(got);
      else cycle();
    end
    rand_on = 0;
    repeat (3) cycle();
    chk_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
